// File: rtl/pixbus_pkg.sv
// pixbus_pkg: shared state type and sizing helpers for the pixel readout bus
package pixbus_pkg;
    typedef enum logic {IDLE, STREAM} state_t;
    function automatic int beats(input int num_ch, input int lanes);
        return num_ch / lanes;
    endfunction
    function automatic int beat_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/gray_to_bin_p.sv
// gray_to_bin_p: combinational W-bit gray to binary converter
module gray_to_bin_p #(
    parameter int W = 8
) (
    input  logic [W-1:0] g,
    output logic [W-1:0] b
);
    always_comb begin
        b = '0;
        for (int i = 0; i < W; i++) b[i] = ^(g >> i);
    end
endmodule

// File: rtl/pixel_readout_bus.sv
// pixel_readout_bus: captures NUM_CH gray pixels, streams binary LANES per beat (optional PIXBUS_PARITY_EN parity)
module pixel_readout_bus
    import pixbus_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int NUM_CH = 4,
    parameter int LANES  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    read_req,
    input  logic [NUM_CH*PIX_W-1:0] pix_data_in,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*PIX_W-1:0]  out_data,
    output logic                    out_last,
    output logic                    overrun
`ifdef PIXBUS_PARITY_EN
    ,
    output logic                    out_parity
`endif
);
    localparam int BEATS = beats(NUM_CH, LANES);
    localparam int BW = beat_w(BEATS);
    localparam int CW = NUM_CH * PIX_W;
    localparam int DW = LANES * PIX_W;
    logic [CW-1:0] conv, cap;
    logic [BW-1:0] beat;
    state_t state;
    logic xfer, last, restart, load, clear, nl;
    logic [DW-1:0] nd;
    for (genvar c = 0; c < NUM_CH; c++) begin : g_conv
        gray_to_bin_p #(.W(PIX_W)) u_g2b (
            .g(pix_data_in[CW-1-c*PIX_W -: PIX_W]),
            .b(conv[CW-1-c*PIX_W -: PIX_W])
        );
    end
    // A new frame starts from IDLE or back-to-back on the last transfer, always at beat 0
    always_comb begin
        last    = int'(beat) == BEATS - 1;
        xfer    = state == STREAM && out_ready;
        restart = state == IDLE || last;
        nd      = restart ? conv[CW-1 -: DW] : cap[CW-1-(int'(beat)+1)*DW -: DW];
        nl      = restart ? (BEATS == 1) : (int'(beat) + 1 == BEATS - 1);
        load    = state == IDLE ? read_req : xfer && (!last || read_req);
        clear   = xfer && last && !read_req;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            beat      <= '0;
            cap       <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (state == STREAM && read_req && !(xfer && last)) overrun <= 1'b1;
            if (clear) begin
                state     <= IDLE;
                busy      <= 1'b0;
                out_valid <= 1'b0;
                out_data  <= '0;
                out_last  <= 1'b0;
            end else if (load) begin
                state     <= STREAM;
                busy      <= 1'b1;
                out_valid <= 1'b1;
                out_data  <= nd;
                out_last  <= nl;
                beat      <= restart ? '0 : beat + 1'b1;
                if (restart) cap <= conv;
            end
        end
    end
`ifdef PIXBUS_PARITY_EN
    always_ff @(posedge clk)
        out_parity <= (reset || clear) ? 1'b0 : load ? ^nd : out_parity;
`endif
endmodule

// File: tb/tb_pixel_readout_bus.sv
// tb_pixel_readout_bus: scoreboard bench with directed scenarios and random traffic
module tb_pixel_readout_bus;
    localparam int PIX_W = 8, NUM_CH = 4, LANES = 2, BEATS = NUM_CH / LANES;
    typedef struct {
        logic [LANES*PIX_W-1:0] d;
        logic l;
    } beat_t;
    logic clk = 0, reset = 1, read_req = 0, out_ready = 0;
    logic [NUM_CH*PIX_W-1:0] pix_data_in = '0;
    logic busy, out_valid, out_last, overrun;
    logic [LANES*PIX_W-1:0] out_data;
`ifdef PIXBUS_PARITY_EN
    logic out_parity;
`endif
    int total = 0, bad = 0;
    beat_t q[$];
    logic exp_ovr = 0;

    pixel_readout_bus #(.PIX_W(PIX_W), .NUM_CH(NUM_CH), .LANES(LANES)) dut (
        .clk(clk), .reset(reset), .read_req(read_req), .pix_data_in(pix_data_in),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .overrun(overrun)
`ifdef PIXBUS_PARITY_EN
        , .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    // Binary value whose gray code equals g, found by search
    function automatic logic [7:0] g2b(input logic [7:0] g);
        for (int v = 0; v < 256; v++) begin
            logic [7:0] t = v[7:0];
            if ((t ^ (t >> 1)) == g) return t;
        end
        return 8'h00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a request is accepted only when no beats of a frame remain outstanding
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            exp_ovr = 0;
        end else if (read_req) begin
            if (q.size() == 0) begin
                for (int j = 0; j < BEATS; j++) begin
                    beat_t b;
                    b.d = '0;
                    for (int k = 0; k < LANES; k++)
                        b.d = (b.d << PIX_W) | (LANES*PIX_W)'(g2b(pix_data_in[NUM_CH*PIX_W-1-(j*LANES+k)*PIX_W -: PIX_W]));
                    b.l = (j == BEATS - 1);
                    q.push_back(b);
                end
            end else exp_ovr = 1;
        end
    end

    // Monitor: compares the presented beat with the scoreboard head, pops on transfer
    always @(negedge clk) begin
        chk("overrun", 32'(overrun), 32'(exp_ovr));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (out_valid && q.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(q[0].d));
            chk("out_last", 32'(out_last), 32'(q[0].l));
`ifdef PIXBUS_PARITY_EN
            chk("out_parity", 32'(out_parity), 32'(^q[0].d));
`endif
            if (out_ready) void'(q.pop_front());
        end else if (!out_valid) begin
            chk("idle_data", 32'(out_data), 32'h0);
            chk("idle_last", 32'(out_last), 32'h0);
`ifdef PIXBUS_PARITY_EN
            chk("idle_parity", 32'(out_parity), 32'h0);
`endif
        end
    end

    task automatic cyc(input logic rst, input logic rr, input logic rdy, input logic [31:0] pix);
        @(posedge clk);
        #1;
        reset = rst;
        read_req = rr;
        out_ready = rdy;
        pix_data_in = pix;
    endtask

    localparam logic [31:0] FA = 32'h80C0_0301, FB = 32'h0101_0101;

    initial begin
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        // plain frame
        cyc(0, 1, 1, FA);
        repeat (4) cyc(0, 0, 1, 0);
        // stall 3 cycles at beat 0 while inputs change
        cyc(0, 1, 0, FA);
        cyc(0, 0, 0, 32'hFFFF_FFFF);
        cyc(0, 0, 0, 32'h1234_5678);
        cyc(0, 0, 0, 32'hA5A5_A5A5);
        repeat (4) cyc(0, 0, 1, 0);
        // request during beat 0 sets sticky overrun
        cyc(0, 1, 0, FA);
        cyc(0, 0, 0, FA);
        cyc(0, 1, 0, FB);
        cyc(0, 0, 1, 0);
        repeat (4) cyc(0, 0, 1, 0);
        // back-to-back request on last transfer
        cyc(1, 0, 0, 0);
        cyc(0, 1, 1, FA);
        cyc(0, 0, 1, 0);
        cyc(0, 1, 1, FB);
        repeat (4) cyc(0, 0, 1, 0);
        // reset while stalled at beat 1, then restart
        cyc(0, 1, 1, FA);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 1, FB);
        repeat (4) cyc(0, 0, 1, 0);
        // randomized traffic
        for (int n = 0; n < 3000; n++)
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 2) != 0, $urandom);
        repeat (8) cyc(0, 0, 1, 0);
        @(posedge clk);
        #1;
        chk("drained", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
